// File: rtl/sprite_palette_bank.sv
// Banked 12-bit sprite palette with a default-table loader, one-cycle lookup
// and a frame-timed hit-flash that whitens non-transparent pixels.
module sprite_palette_bank #(
  parameter int IDX_W           = 4,
  parameter int N_BANKS         = 4,
  parameter int FLASH_FRAMES    = 8,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pix_valid_i,
  input  logic [$clog2(N_BANKS)-1:0] pix_bank_i,
  input  logic [IDX_W-1:0]           pix_index_i,
  output logic                       out_valid_o,
  output logic [3:0]                 red_o,
  output logic [3:0]                 green_o,
  output logic [3:0]                 blue_o,
  output logic                       out_transparent_o,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [$clog2(N_BANKS)-1:0] wr_bank_i,
  input  logic [IDX_W-1:0]           wr_index_i,
  input  logic [11:0]                wr_rgb_i,
  input  logic                       flash_start_i,
  input  logic                       frame_start_i,
  output logic                       flashing_o,
  output logic                       init_done_o
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = N_BANKS * (2 ** IDX_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  TRANSP    = IDX_W'(TRANSPARENT_IDX);
  localparam logic [7:0]        FLASH_LD  = 8'(FLASH_FRAMES);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [11:0]         mem_q [DEPTH];
  logic [11:0]         rgb_q;
  logic                out_valid_q;
  logic                transp_q;
  logic [7:0]          flash_cnt_q;
  logic                run;
  logic                lookup;
  logic                wr_fire;
  logic [ADDR_W-1:0]   pix_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic                pix_transp;

  // Default entry: grey level equal to the low nibble of the colour index.
  function automatic logic [11:0] init_rgb(input logic [ADDR_W-1:0] a);
    logic [3:0] d;
    d = 4'(a[IDX_W-1:0]);
    return {d, d, d};
  endfunction

  function automatic logic [11:0] flash_mix(input logic [11:0] c,
                                            input logic fl, input logic tr);
    return (fl && !tr) ? 12'hFFF : c;
  endfunction

  assign run        = (state_q == S_RUN);
  assign lookup     = run && pix_valid_i;
  assign wr_fire    = run && wr_valid_i;
  assign pix_addr   = {pix_bank_i, pix_index_i};
  assign wr_addr    = {wr_bank_i, wr_index_i};
  assign pix_transp = (pix_index_i == TRANSP);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_INIT: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) state_d = S_RUN;
      end
      S_RUN: ;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_INIT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Storage: nonblocking update gives read-before-write on a shared address.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (!run)         mem_q[addr_q]  <= init_rgb(addr_q);
      else if (wr_fire) mem_q[wr_addr] <= wr_rgb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      transp_q    <= 1'b0;
      rgb_q       <= '0;
    end else begin
      out_valid_q <= lookup;
      transp_q    <= lookup && pix_transp;
      if (lookup) rgb_q <= flash_mix(mem_q[pix_addr], flash_cnt_q != 8'd0, pix_transp);
    end
  end

  // Flash countdown runs regardless of INIT/RUN; a new hit always reloads.
  always_ff @(posedge clk_i) begin
    if (reset_i)                                flash_cnt_q <= 8'd0;
    else if (flash_start_i)                     flash_cnt_q <= FLASH_LD;
    else if (frame_start_i && flash_cnt_q != 0) flash_cnt_q <= flash_cnt_q - 8'd1;
  end

  assign out_valid_o       = out_valid_q;
  assign out_transparent_o = transp_q;
  assign red_o             = rgb_q[11:8];
  assign green_o           = rgb_q[7:4];
  assign blue_o            = rgb_q[3:0];
  assign wr_ready_o        = run;
  assign init_done_o       = run;
  assign flashing_o        = (flash_cnt_q != 8'd0);

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank with default parameters (4 banks x 16).
module tb_sprite_palette_bank;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       pix_valid_i;
  logic [1:0] pix_bank_i;
  logic [3:0] pix_index_i;
  logic       out_valid_o;
  logic [3:0] red_o, green_o, blue_o;
  logic       out_transparent_o;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [1:0] wr_bank_i;
  logic [3:0] wr_index_i;
  logic [11:0] wr_rgb_i;
  logic       flash_start_i;
  logic       frame_start_i;
  logic       flashing_o;
  logic       init_done_o;

  int errors = 0;
  int checks = 0;
  int n;
  logic seen_valid;

  sprite_palette_bank dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pix_valid_i(pix_valid_i), .pix_bank_i(pix_bank_i), .pix_index_i(pix_index_i),
    .out_valid_o(out_valid_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .out_transparent_o(out_transparent_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_bank_i(wr_bank_i),
    .wr_index_i(wr_index_i), .wr_rgb_i(wr_rgb_i),
    .flash_start_i(flash_start_i), .frame_start_i(frame_start_i),
    .flashing_o(flashing_o), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [1:0] b, input logic [3:0] i);
    pix_valid_i = 1'b1; pix_bank_i = b; pix_index_i = i;
    step();
    pix_valid_i = 1'b0;
  endtask

  task automatic write(input logic [1:0] b, input logic [3:0] i, input logic [11:0] c);
    wr_valid_i = 1'b1; wr_bank_i = b; wr_index_i = i; wr_rgb_i = c;
    step();
    wr_valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; pix_valid_i = 1'b0; pix_bank_i = '0; pix_index_i = '0;
    wr_valid_i = 1'b0; wr_bank_i = '0; wr_index_i = '0; wr_rgb_i = '0;
    flash_start_i = 1'b0; frame_start_i = 1'b0;
    step(); step();
    check("rst_rgb", {red_o, green_o, blue_o}, 12'h000);
    check("rst_ctrl", {6'd0, out_valid_o, out_transparent_o, wr_ready_o, init_done_o, flashing_o, 1'b0}, 12'h000);

    // INIT length, with lookups requested throughout
    reset_i = 1'b0; pix_valid_i = 1'b1; pix_bank_i = 2'd2; pix_index_i = 4'd5;
    n = 0; seen_valid = 1'b0;
    while (!init_done_o && n < 200) begin
      if (wr_ready_o || out_valid_o) seen_valid = 1'b1;
      step(); n++;
    end
    if (out_valid_o) seen_valid = 1'b1;
    pix_valid_i = 1'b0;
    check("init_cycles", 12'(n), 12'd64);
    check("init_no_valid", {11'd0, seen_valid}, 12'h000);
    check("run_wr_ready", {11'd0, wr_ready_o}, 12'h001);

    lookup(2'd2, 4'd5);
    check("lk_b2i5_valid", {11'd0, out_valid_o}, 12'h001);
    check("lk_b2i5", {red_o, green_o, blue_o}, 12'h555);
    step();
    check("idle_valid", {11'd0, out_valid_o}, 12'h000);
    check("idle_hold", {red_o, green_o, blue_o}, 12'h555);

    write(2'd1, 4'd3, 12'hD86);
    lookup(2'd1, 4'd3);
    check("wr_b1i3", {red_o, green_o, blue_o}, 12'hD86);
    lookup(2'd0, 4'd3);
    check("b0i3_default", {red_o, green_o, blue_o}, 12'h333);

    // same-cycle write and lookup
    wr_valid_i = 1'b1; wr_bank_i = 2'd0; wr_index_i = 4'd7; wr_rgb_i = 12'hF00;
    pix_valid_i = 1'b1; pix_bank_i = 2'd0; pix_index_i = 4'd7;
    step();
    wr_valid_i = 1'b0; pix_valid_i = 1'b0;
    check("rbw_old", {red_o, green_o, blue_o}, 12'h777);
    lookup(2'd0, 4'd7);
    check("rbw_new", {red_o, green_o, blue_o}, 12'hF00);

    write(2'd2, 4'd0, 12'h123);
    lookup(2'd2, 4'd0);
    check("transp_rgb", {red_o, green_o, blue_o}, 12'h123);
    check("transp_flag", {11'd0, out_transparent_o}, 12'h001);

    // hit flash
    flash_start_i = 1'b1; step(); flash_start_i = 1'b0;
    check("flash_on", {11'd0, flashing_o}, 12'h001);
    lookup(2'd0, 4'd4);
    check("flash_b0i4", {red_o, green_o, blue_o}, 12'hFFF);
    check("flash_nontransp", {11'd0, out_transparent_o}, 12'h000);
    lookup(2'd1, 4'd3);
    check("flash_b1i3", {red_o, green_o, blue_o}, 12'hFFF);
    lookup(2'd2, 4'd0);
    check("flash_transp_rgb", {red_o, green_o, blue_o}, 12'h123);
    check("flash_transp_flag", {11'd0, out_transparent_o}, 12'h001);
    frame_start_i = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("flash_7frames", {11'd0, flashing_o}, 12'h001);
    step();
    frame_start_i = 1'b0;
    check("flash_8frames", {11'd0, flashing_o}, 12'h000);
    lookup(2'd0, 4'd4);
    check("after_flash_b0i4", {red_o, green_o, blue_o}, 12'h444);

    // load beats decrement when coincident at count 2
    flash_start_i = 1'b1; step(); flash_start_i = 1'b0;
    frame_start_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    flash_start_i = 1'b1; step(); flash_start_i = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("coinc_7frames", {11'd0, flashing_o}, 12'h001);
    step();
    check("coinc_8frames", {11'd0, flashing_o}, 12'h000);
    step();
    frame_start_i = 1'b0;
    check("no_underflow", {11'd0, flashing_o}, 12'h000);

    // reset mid-RUN with a write presented in the same cycle
    reset_i = 1'b1;
    wr_valid_i = 1'b1; wr_bank_i = 2'd2; wr_index_i = 4'd9; wr_rgb_i = 12'hABC;
    step();
    wr_valid_i = 1'b0;
    check("rst2_rgb", {red_o, green_o, blue_o}, 12'h000);
    check("rst2_ctrl", {9'd0, init_done_o, wr_ready_o, out_valid_o}, 12'h000);
    reset_i = 1'b0;
    flash_start_i = 1'b1; step(); flash_start_i = 1'b0;
    n = 1;
    check("flash_in_init", {10'd0, flashing_o, init_done_o}, 12'h002);
    while (!init_done_o && n < 200) begin
      step(); n++;
    end
    check("reinit_cycles", 12'(n), 12'd64);
    frame_start_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    frame_start_i = 1'b0;
    check("reinit_flash_off", {11'd0, flashing_o}, 12'h000);
    lookup(2'd1, 4'd3);
    check("restored_b1i3", {red_o, green_o, blue_o}, 12'h333);
    lookup(2'd2, 4'd9);
    check("discarded_b2i9", {red_o, green_o, blue_o}, 12'h999);
    lookup(2'd3, 4'd15);
    check("b3i15_default", {red_o, green_o, blue_o}, 12'hFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
